seat_table_ctrl: RTL and testbench

Clocked, parametrised seat-reservation table for the school seating system. It stores owner student number, timestamp and state per seat, and serves one check-in/state-change request at a time over a valid/ready handshake with a coded response. It also applies manager ban/limit configuration and runs a background timeout sweep that auto-returns expired seats. It sits between the kiosk/request front-end and the manager console.

---
 rtl/seat_pkg.sv | 41 ++++
 rtl/seat_expire_chk.sv | 23 ++
 rtl/seat_table_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_seat_table_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seat_pkg.sv
// Shared types and encodings for the seat reservation table: seat states,
// response codes, manager configuration commands and ban-mode helpers.
package seat_pkg;

    typedef enum logic [1:0] {
        SEAT_FREE     = 2'd0,
        SEAT_AWAY     = 2'd1,
        SEAT_OCCUPIED = 2'd2,
        SEAT_BANNED   = 2'd3
    } seat_state_e;

    typedef enum logic [2:0] {
        RESP_OK_CHANGE     = 3'd0,
        RESP_OK_CHECKOUT   = 3'd1,
        RESP_DENY_BANNED   = 3'd2,
        RESP_DENY_OTHER    = 3'd3,
        RESP_DENY_OWNER    = 3'd4,
        RESP_DENY_NOCHANGE = 3'd5,
        RESP_DENY_RANGE    = 3'd6
    } resp_code_e;

    // Manager console command on cfg_write
    localparam logic [1:0] CFG_NONE  = 2'd0;
    localparam logic [1:0] CFG_BAN   = 2'd1;
    localparam logic [1:0] CFG_LIMIT = 2'd2;

    // Ban modes on cfg_ban; any value with bit 1 set means "unban all"
    localparam logic [1:0] BAN_EVEN = 2'd0;
    localparam logic [1:0] BAN_ODD  = 2'd1;

    // True when a ban of the given mode targets seat idx (parity match).
    function automatic logic ban_parity_hit(input int unsigned idx, input logic [1:0] mode);
        return !mode[1] && ((idx & 32'd1) == 32'(mode[0]));
    endfunction

    // True when the mode releases every banned seat.
    function automatic logic ban_is_unban(input logic [1:0] mode);
        return mode[1];
    endfunction

endpackage

// File: rtl/seat_expire_chk.sv
// Elapsed-time comparator for one seat: an AWAY seat has expired once the
// time since its stamp, taken modulo 2^TIME_W, strictly exceeds the limit.
module seat_expire_chk
    import seat_pkg::*;
#(
    parameter int TIME_W = 11
) (
    input  seat_state_e        state,
    input  logic [TIME_W-1:0]  stamp,
    input  logic [TIME_W-1:0]  now_time,
    input  logic [TIME_W-1:0]  limit,
    output logic               expired
);

    logic [TIME_W-1:0] elapsed;

    // Wrapping subtraction gives the modular elapsed time directly
    always_comb begin
        elapsed = now_time - stamp;
        expired = (state == SEAT_AWAY) && (elapsed > limit);
    end

endmodule

// File: rtl/seat_table_ctrl.sv
// Seat reservation table. Holds owner, timestamp and state per seat, serves
// one kiosk request at a time (full-table scan, then a single commit cycle),
// applies manager ban/limit commands and sweeps the table for expired AWAY
// seats whenever the current time changes.
module seat_table_ctrl
    import seat_pkg::*;
#(
    parameter int N_SEATS = 32,
    parameter int SID_W   = 32,
    parameter int TIME_W  = 11,
    localparam int SEAT_W = $clog2(N_SEATS)
) (
    input  logic               clk_mem,
    input  logic               rst_mem,
    input  logic [TIME_W-1:0]  now_time,
    input  logic [1:0]         cfg_write,
    input  logic [1:0]         cfg_ban,
    input  logic [TIME_W-1:0]  cfg_limit,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [SID_W-1:0]   req_student,
    input  logic [SEAT_W-1:0]  req_seat,
    input  logic [1:0]         req_state,
    output logic               resp_valid,
    output logic [2:0]         resp_code,
    output logic               expire_valid,
    output logic [SEAT_W-1:0]  expire_seat,
    output logic [SID_W-1:0]   expire_student
);

    localparam logic [1:0] FSM_IDLE   = 2'd0;
    localparam logic [1:0] FSM_CHECK  = 2'd1;
    localparam logic [1:0] FSM_COMMIT = 2'd2;
    localparam logic [1:0] FSM_SWEEP  = 2'd3;

    // Seat table
    logic [SID_W-1:0]  owner      [N_SEATS];
    logic [TIME_W-1:0] stamp      [N_SEATS];
    seat_state_e       seat_state [N_SEATS];

    // Control state
    logic [1:0]        fsm;
    logic [SEAT_W-1:0] scan_idx;
    logic [TIME_W-1:0] limit;
    logic [TIME_W-1:0] prev_time;
    logic              sweep_pending;
    logic              ban_defer;
    logic [1:0]        ban_defer_mode;

    // Latched request
    logic [SID_W-1:0]  lat_student;
    logic [SEAT_W-1:0] lat_seat;
    seat_state_e       lat_state;
    logic              lat_range_err;
    logic              lat_other;

    // Derived control
    logic              scan_last;
    logic              req_range_err;
    logic              accept;
    logic              sweep_start;
    logic              time_moved;
    logic              check_hit;
    logic              scan_expired;
    logic              sweep_expire;
    logic [1:0]        ban_en;
    logic [1:0][1:0]   ban_mode;

    // Commit decision
    seat_state_e       tgt_state;
    logic [SID_W-1:0]  tgt_owner;
    resp_code_e        commit_code;
    logic              commit_set;
    logic              commit_clear;

    assign req_ready     = !rst_mem && (fsm == FSM_IDLE) && (cfg_write == CFG_NONE) && !sweep_pending;
    assign accept        = req_valid && req_ready;
    assign sweep_start   = (fsm == FSM_IDLE) && (cfg_write == CFG_NONE) && sweep_pending;
    assign time_moved    = (now_time != prev_time);
    assign scan_last     = (scan_idx == SEAT_W'(N_SEATS - 1));
    assign req_range_err = ({1'b0, req_seat} >= (SEAT_W + 1)'(N_SEATS));

    seat_expire_chk #(
        .TIME_W   (TIME_W)
    ) u_expire_chk (
        .state    (seat_state[scan_idx]),
        .stamp    (stamp[scan_idx]),
        .now_time (now_time),
        .limit    (limit),
        .expired  (scan_expired)
    );

    // Ban slots for this cycle: slot 0 replays a ban held over from COMMIT,
    // slot 1 is a live ban command (held over instead when it lands in COMMIT)
    always_comb begin
        ban_en[0]   = ban_defer;
        ban_mode[0] = ban_defer_mode;
        ban_en[1]   = (cfg_write == CFG_BAN) && (fsm != FSM_COMMIT);
        ban_mode[1] = cfg_ban;
    end

    // Per-cycle scan tests: another seat held by the requester, and whether
    // the sweep may retire the visited seat (a same-cycle ban on it wins)
    always_comb begin
        check_hit    = (scan_idx != lat_seat) && (owner[scan_idx] != '0) &&
                       (owner[scan_idx] == lat_student);
        sweep_expire = (fsm == FSM_SWEEP) && scan_expired &&
                       !(ban_en[1] && ban_parity_hit(32'(scan_idx), ban_mode[1]));
    end

    // Commit decision against the live table, in priority order
    always_comb begin
        tgt_state    = SEAT_FREE;
        tgt_owner    = '0;
        commit_code  = RESP_DENY_RANGE;
        commit_set   = 1'b0;
        commit_clear = 1'b0;
        if (!lat_range_err) begin
            tgt_state = seat_state[lat_seat];
            tgt_owner = owner[lat_seat];
            if (tgt_state == SEAT_BANNED) begin
                commit_code = RESP_DENY_BANNED;
            end else if ((tgt_owner != '0) && (tgt_owner != lat_student)) begin
                commit_code = RESP_DENY_OWNER;
            end else if (lat_other) begin
                commit_code = RESP_DENY_OTHER;
            end else if (lat_state == tgt_state) begin
                commit_code = RESP_DENY_NOCHANGE;
            end else if (lat_state == SEAT_FREE) begin
                commit_code  = RESP_OK_CHECKOUT;
                commit_clear = 1'b1;
            end else if ((lat_state == SEAT_BANNED) ||
                         ((tgt_state == SEAT_FREE) && (lat_state == SEAT_AWAY))) begin
                commit_code = RESP_DENY_NOCHANGE;
            end else begin
                commit_code = RESP_OK_CHANGE;
                commit_set  = 1'b1;
            end
        end
    end

    // Sequencer, seat table and configuration registers
    always_ff @(posedge clk_mem) begin
        if (rst_mem) begin
            for (int i = 0; i < N_SEATS; i++) begin
                owner[i]      <= '0;
                stamp[i]      <= '0;
                seat_state[i] <= ban_parity_hit(unsigned'(i), cfg_ban) ? SEAT_BANNED : SEAT_FREE;
            end
            fsm            <= FSM_IDLE;
            scan_idx       <= '0;
            limit          <= '0;
            prev_time      <= now_time;
            sweep_pending  <= 1'b0;
            ban_defer      <= 1'b0;
            ban_defer_mode <= BAN_EVEN;
            lat_student    <= '0;
            lat_seat       <= '0;
            lat_state      <= SEAT_FREE;
            lat_range_err  <= 1'b0;
            lat_other      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_code      <= '0;
            expire_valid   <= 1'b0;
            expire_seat    <= '0;
            expire_student <= '0;
        end else begin
            resp_valid   <= 1'b0;
            expire_valid <= 1'b0;

            if (time_moved) begin
                prev_time     <= now_time;
                sweep_pending <= 1'b1;
            end else if (sweep_start) begin
                sweep_pending <= 1'b0;
            end

            if (cfg_write == CFG_LIMIT) begin
                limit <= cfg_limit;
            end

            case (fsm)
                FSM_IDLE: begin
                    if (sweep_start) begin
                        fsm      <= FSM_SWEEP;
                        scan_idx <= '0;
                    end else if (accept) begin
                        lat_student   <= req_student;
                        lat_seat      <= req_seat;
                        lat_state     <= seat_state_e'(req_state);
                        lat_range_err <= req_range_err;
                        lat_other     <= 1'b0;
                        scan_idx      <= '0;
                        fsm           <= req_range_err ? FSM_COMMIT : FSM_CHECK;
                    end
                end
                FSM_CHECK: begin
                    if (check_hit) begin
                        lat_other <= 1'b1;
                    end
                    if (scan_last) begin
                        fsm <= FSM_COMMIT;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                FSM_COMMIT: begin
                    resp_valid <= 1'b1;
                    resp_code  <= commit_code;
                    if (commit_clear) begin
                        owner[lat_seat]      <= '0;
                        stamp[lat_seat]      <= '0;
                        seat_state[lat_seat] <= SEAT_FREE;
                    end else if (commit_set) begin
                        owner[lat_seat]      <= lat_student;
                        stamp[lat_seat]      <= now_time;
                        seat_state[lat_seat] <= lat_state;
                    end
                    fsm <= FSM_IDLE;
                end
                default: begin
                    if (sweep_expire) begin
                        owner[scan_idx]      <= '0;
                        stamp[scan_idx]      <= '0;
                        seat_state[scan_idx] <= SEAT_FREE;
                        expire_valid         <= 1'b1;
                        expire_seat          <= scan_idx;
                        expire_student       <= owner[scan_idx];
                    end
                    if (scan_last) begin
                        fsm <= FSM_IDLE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
            endcase

            if ((fsm == FSM_COMMIT) && (cfg_write == CFG_BAN)) begin
                ban_defer      <= 1'b1;
                ban_defer_mode <= cfg_ban;
            end else begin
                ban_defer <= 1'b0;
            end

            for (int i = 0; i < N_SEATS; i++) begin
                for (int k = 0; k < 2; k++) begin
                    if (ban_en[k]) begin
                        if (ban_parity_hit(unsigned'(i), ban_mode[k])) begin
                            owner[i]      <= '0;
                            stamp[i]      <= '0;
                            seat_state[i] <= SEAT_BANNED;
                        end else if (ban_is_unban(ban_mode[k]) && (seat_state[i] == SEAT_BANNED)) begin
                            seat_state[i] <= SEAT_FREE;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seat_table_ctrl.sv
// Scoreboard bench for seat_table_ctrl: stimulus pushes expected responses
// and expiries into queues, a negedge monitor pops and compares them.
module tb_seat_table_ctrl;

    localparam int N_SEATS = 32;
    localparam int SID_W   = 32;
    localparam int TIME_W  = 11;
    localparam int SEAT_W  = 5;
    localparam int LAT     = N_SEATS + 1;

    logic               clk_mem = 1'b0;
    logic               rst_mem;
    logic [TIME_W-1:0]  now_time;
    logic [1:0]         cfg_write;
    logic [1:0]         cfg_ban;
    logic [TIME_W-1:0]  cfg_limit;
    logic               req_valid;
    logic               req_ready;
    logic [SID_W-1:0]   req_student;
    logic [SEAT_W-1:0]  req_seat;
    logic [1:0]         req_state;
    logic               resp_valid;
    logic [2:0]         resp_code;
    logic               expire_valid;
    logic [SEAT_W-1:0]  expire_seat;
    logic [SID_W-1:0]   expire_student;

    seat_table_ctrl #(
        .N_SEATS (N_SEATS),
        .SID_W   (SID_W),
        .TIME_W  (TIME_W)
    ) dut (
        .clk_mem        (clk_mem),
        .rst_mem        (rst_mem),
        .now_time       (now_time),
        .cfg_write      (cfg_write),
        .cfg_ban        (cfg_ban),
        .cfg_limit      (cfg_limit),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_student    (req_student),
        .req_seat       (req_seat),
        .req_state      (req_state),
        .resp_valid     (resp_valid),
        .resp_code      (resp_code),
        .expire_valid   (expire_valid),
        .expire_seat    (expire_seat),
        .expire_student (expire_student)
    );

    always #5 clk_mem = ~clk_mem;

    int cyc = 0;
    always @(posedge clk_mem) cyc <= cyc + 1;

    typedef struct { int code; int due; } resp_exp_t;
    typedef struct { int seat; int sid; } expire_exp_t;

    resp_exp_t   rq[$];
    expire_exp_t xq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT strobe must match the oldest outstanding expectation
    always @(negedge clk_mem) begin
        if (resp_valid === 1'b1) begin
            check("resp_expected", 64'(rq.size() > 0), 1);
            if (rq.size() > 0) begin
                resp_exp_t e;
                e = rq.pop_front();
                check("resp_code", 64'(resp_code), 64'(e.code));
                check("resp_latency_cycle", 64'(cyc), 64'(e.due));
            end
        end
        if (expire_valid === 1'b1) begin
            check("expire_expected", 64'(xq.size() > 0), 1);
            if (xq.size() > 0) begin
                expire_exp_t x;
                x = xq.pop_front();
                check("expire_seat", 64'(expire_seat), 64'(x.seat));
                check("expire_student", 64'(expire_student), 64'(x.sid));
            end
        end
    end

    task automatic drain(input int max_cyc);
        int g = 0;
        while ((rq.size() != 0 || xq.size() != 0) && g < max_cyc) begin
            @(posedge clk_mem);
            g++;
        end
        check("drain_in_time", 64'(rq.size() == 0 && xq.size() == 0), 1);
    endtask

    // Present a request, wait (bounded) for acceptance, optionally expect a response
    task automatic do_req(input int sid, input int seat, input int st, input int code,
                          input bit expect_it, input bit wait_done);
        int guard = 0;
        int acc;
        @(posedge clk_mem); #1;
        req_valid   = 1'b1;
        req_student = sid;
        req_seat    = seat[SEAT_W-1:0];
        req_state   = st[1:0];
        #1;
        while (!req_ready && guard < 300) begin
            @(posedge clk_mem); #1;
            guard++;
        end
        if (!req_ready) begin
            check("req_accept_in_time", 0, 1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk_mem); #1;
            acc = cyc;
            req_valid = 1'b0;
            if (expect_it) rq.push_back('{code, acc + LAT});
            if (wait_done) drain(100);
        end
    endtask

    task automatic set_time(input int t);
        @(posedge clk_mem); #1;
        now_time = t[TIME_W-1:0];
    endtask

    task automatic cfg(input logic [1:0] w, input logic [1:0] b, input int l);
        @(posedge clk_mem); #1;
        cfg_write = w;
        cfg_ban   = b;
        cfg_limit = l[TIME_W-1:0];
        @(posedge clk_mem); #1;
        cfg_write = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_mem     = 1'b1;
        cfg_ban     = 2'd1;
        now_time    = '0;
        cfg_write   = 2'd0;
        cfg_limit   = '0;
        req_valid   = 1'b0;
        req_student = '0;
        req_seat    = '0;
        req_state   = '0;

        // Reset with odd seats banned
        repeat (3) @(posedge clk_mem);
        #1;
        check("ready_during_reset", 64'(req_ready), 0);
        @(posedge clk_mem); #1;
        rst_mem = 1'b0;
        #1;
        check("reset_resp_valid", 64'(resp_valid), 0);
        check("reset_resp_code", 64'(resp_code), 0);
        check("reset_expire_valid", 64'(expire_valid), 0);
        check("reset_expire_seat", 64'(expire_seat), 0);
        check("reset_expire_student", 64'(expire_student), 0);
        check("ready_after_reset", 64'(req_ready), 1);

        do_req(1001, 3, 2, 2, 1, 1);          // odd seat banned
        set_time(10);
        do_req(1001, 4, 2, 0, 1, 1);          // take seat 4
        do_req(1001, 4, 0, 1, 1, 1);          // check out
        do_req(1001, 4, 0, 5, 1, 1);          // already free
        do_req(1001, 4, 2, 0, 1, 1);          // retake
        do_req(2002, 4, 2, 4, 1, 1);          // someone else's seat
        do_req(1001, 6, 2, 3, 1, 1);          // already holds another seat

        // Timeout: limit 5, AWAY stamped at 10
        cfg(2'd2, 2'd1, 5);
        do_req(1001, 4, 1, 0, 1, 1);
        set_time(15);
        repeat (45) @(posedge clk_mem);       // elapsed 5, not beyond limit
        xq.push_back('{4, 1001});
        set_time(16);
        drain(100);
        do_req(1001, 4, 0, 5, 1, 1);          // seat returned to FREE

        // Wrapping time: stamp 2045, now 3 -> elapsed 6
        set_time(2045);
        do_req(1001, 4, 2, 0, 1, 1);
        do_req(1001, 4, 1, 0, 1, 1);
        cfg(2'd2, 2'd1, 4);
        xq.push_back('{4, 1001});
        set_time(3);
        drain(100);
        set_time(2045);
        do_req(1001, 4, 2, 0, 1, 1);
        do_req(1001, 4, 1, 0, 1, 1);
        cfg(2'd2, 2'd1, 6);
        set_time(3);
        repeat (45) @(posedge clk_mem);       // elapsed 6 equals limit
        do_req(1001, 4, 0, 1, 1, 1);          // still owned -> checkout

        // Unban all, then a ban landing mid-scan
        cfg(2'd1, 2'd2, 0);
        do_req(5005, 3, 2, 0, 1, 1);
        do_req(3003, 8, 2, 2, 1, 0);
        repeat (4) @(posedge clk_mem);
        cfg(2'd1, 2'd0, 0);
        drain(100);

        // Reset in the middle of a scan drops the request
        do_req(5005, 5, 2, 0, 0, 0);
        repeat (5) @(posedge clk_mem);
        #1;
        rst_mem = 1'b1;
        cfg_ban = 2'd2;
        #1;
        check("ready_low_in_midscan_reset", 64'(req_ready), 0);
        @(posedge clk_mem); #1;
        rst_mem = 1'b0;
        #1;
        check("post_reset_resp_valid", 64'(resp_valid), 0);
        check("post_reset_expire_valid", 64'(expire_valid), 0);
        repeat (45) @(posedge clk_mem);
        do_req(6006, 3, 2, 0, 1, 1);          // previous owner cleared

        drain(100);
        check("scoreboard_empty", 64'(rq.size() + xq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
